operand_fetch_ctrl: RTL
=======================

// Module: operand_fetch_ctrl
// PURPOSE
//   Sequencer between the 9-bit dual-read operand memory and the radix-8 Booth multiplier.
//   - On Start, walks Count consecutive addresses from Base_Addr.
//   - Reads each multiplicand/multiplier pair (Data1_O/Data2_O).
//   - Issues each pair to the multiplier over a valid/ready handshake.
//   - Memory is read-only from here: W_En is held 0.
// PARAMETERS
//   DATA_WIDTH  9  operand width; matches memory word
//   ADDR_WIDTH  4  memory address width
//   READ_LAT    1  cycles from Addr change to valid Data1_O/Data2_O (>=0)
// PORTS
//   Clk        in   1             clock, rising edge
//   Rst        in   1             synchronous, active-high reset
//   Start      in   1             begin a run; sampled only in IDLE
//   Base_Addr  in   ADDR_WIDTH    first address of the run
//   Count      in   ADDR_WIDTH+1  number of pairs, 0..2**ADDR_WIDTH
//   Bank_Sel   in   1             memory select, latched at Start
//   Addr       out  ADDR_WIDTH    memory read address
//   W_En       out  1             memory write enable, constant 0
//   M_Sel      out  1             memory select = latched Bank_Sel
//   Data1_O    in   DATA_WIDTH    memory read port 1 (multiplicand)
//   Data2_O    in   DATA_WIDTH    memory read port 2 (multiplier)
//   Op_A       out  DATA_WIDTH    multiplicand to Booth stage
//   Op_B       out  DATA_WIDTH    multiplier to Booth stage
//   Op_Valid   out  1             Op_A/Op_B valid
//   Op_Ready   in   1             Booth stage accepts the pair
//   Busy       out  1             high in any state except IDLE
//   Done       out  1             one-cycle pulse at end of run
// BEHAVIOUR
//   - Reset: state=IDLE; Addr, M_Sel, Op_A, Op_B, Op_Valid, Busy, Done = 0; internal idx and wait counters = 0.
//   - States: IDLE, FETCH, ISSUE, DONE.
//   - IDLE:
//     - Start=1, Count>0: at the same edge, Addr<=Base_Addr, latch Count and Bank_Sel, idx<=0, go to FETCH.
//     - Start=1, Count=0: go to DONE directly; no memory access, no issue.
//   - FETCH: lasts READ_LAT+1 cycles (wait counter). On the last edge: Op_A<=Data1_O, Op_B<=Data2_O, Op_Valid<=1, go to ISSUE.
//   - ISSUE: Op_A/Op_B/Op_Valid held stable until Op_Valid&&Op_Ready. On that edge:
//     - Op_Valid<=0.
//     - idx==Count-1: go to DONE.
//     - else: idx<=idx+1, Addr<=Addr+1, go to FETCH.
//   - DONE: Done=1 for exactly this cycle, then IDLE. Busy=0 from the IDLE cycle on.
//   - Latency: Start sampled at edge k -> Op_Valid high from edge k+READ_LAT+1.
//   - Throughput: with Op_Ready tied 1, one pair per READ_LAT+2 cycles.
//   - Addr wraps modulo 2**ADDR_WIDTH (Base_Addr=14, Count=4 -> 14,15,0,1).
//   - Count=2**ADDR_WIDTH: every word read once; idx compare uses ADDR_WIDTH+1 bits.
//   - Start while Busy: ignored. Base_Addr, Count and Bank_Sel changes mid-run: no effect.
//   - Op_Ready while Op_Valid=0: ignored.
//   - Rst mid-run: abort, return to reset values next edge; no Done pulse.
//   - W_En=0 always, including during reset.
// CONFIGURATION
//   ZERO_SKIP_EN defined:
//     - In FETCH, if Data1_O==0 or Data2_O==0 (product trivially 0), the pair is not issued.
//     - idx/Addr advance as if accepted; at the last pair, go to DONE.
//     - Extra output Skip_Cnt [ADDR_WIDTH:0]: cleared at Start, +1 per skipped pair, held after Done, reset 0.
//   ZERO_SKIP_EN undefined: every pair issued; Skip_Cnt port absent.
// TESTING
//   - Reset: Rst=1 for 2 cycles mid-run -> all outputs 0, state IDLE, no Done; W_En=0 throughout.
//   - Basic run: mem[3..5]={(10,3),(7,7),(256,2)}, Base_Addr=3, Count=3, Op_Ready=1, READ_LAT=1
//     -> Op_Valid at edges k+2, k+5, k+8 with those pairs; Done pulse one cycle after last accept.
//   - Backpressure: Op_Ready=0 for 5 cycles during first issue -> Op_A=10/Op_B=3 held stable;
//     Addr stays 3; accept on Op_Ready=1.
//   - Wrap and full: Base_Addr=14, Count=4 -> Addr 14,15,0,1.
//     Base_Addr=0, Count=16 -> 16 issues, Done once.
//   - Count=0 / Start while Busy: Count=0 -> Done 1 cycle after Start, no Op_Valid.
//     Start pulsed mid-run -> run unchanged.
//   - ZERO_SKIP_EN: pairs (0,5),(4,6),(9,0), Count=3 -> only (4,6) issued; Skip_Cnt=2; Done asserted.

Source files
------------

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: walks Count addresses from Base_Addr, reads operand pairs and issues them
// to the Booth multiplier over valid/ready. Optional macro ZERO_SKIP_EN drops pairs with a zero operand.
module operand_fetch_ctrl #(
    parameter int unsigned DATA_WIDTH = 9,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_Addr,
    input  logic [ADDR_WIDTH:0]   Count,
    input  logic                  Bank_Sel,
    output logic [ADDR_WIDTH-1:0] Addr,
    output logic                  W_En,
    output logic                  M_Sel,
    input  logic [DATA_WIDTH-1:0] Data1_O,
    input  logic [DATA_WIDTH-1:0] Data2_O,
    output logic [DATA_WIDTH-1:0] Op_A,
    output logic [DATA_WIDTH-1:0] Op_B,
    output logic                  Op_Valid,
    input  logic                  Op_Ready,
    output logic                  Busy,
    output logic                  Done
`ifdef ZERO_SKIP_EN
    ,
    output logic [ADDR_WIDTH:0]   Skip_Cnt
`endif
);

    localparam int unsigned WAIT_W = (READ_LAT == 0) ? 1 : $clog2(READ_LAT + 1);
    localparam logic [WAIT_W-1:0]     WAIT_LAST = WAIT_W'(READ_LAT);
    localparam logic [WAIT_W-1:0]     WAIT_ONE  = WAIT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   IDX_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    m_sel_q, m_sel_d;
    logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
    logic                    op_valid_q, op_valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    last_pair;
    logic                    skip_pair;

`ifdef ZERO_SKIP_EN
    logic [ADDR_WIDTH:0]     skip_cnt_q, skip_cnt_d;
    assign skip_pair = (Data1_O == '0) || (Data2_O == '0);
    assign Skip_Cnt  = skip_cnt_q;
`else
    assign skip_pair = 1'b0;
`endif

    // idx and Count share ADDR_WIDTH+1 bits so a full 2**ADDR_WIDTH run terminates correctly
    assign last_pair = (idx_q == (cnt_q - IDX_ONE));

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        m_sel_d    = m_sel_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_valid_d = op_valid_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        wait_d     = wait_q;
`ifdef ZERO_SKIP_EN
        skip_cnt_d = skip_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
`ifdef ZERO_SKIP_EN
                    skip_cnt_d = '0;
`endif
                    if (Count != '0) begin
                        state_d = S_FETCH;
                        addr_d  = Base_Addr;
                        cnt_d   = Count;
                        m_sel_d = Bank_Sel;
                        idx_d   = '0;
                        wait_d  = '0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d = '0;
                    if (skip_pair) begin
                        // Trivially-zero product: advance exactly as if the pair had been accepted
`ifdef ZERO_SKIP_EN
                        skip_cnt_d = skip_cnt_q + IDX_ONE;
`endif
                        if (last_pair) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d  = idx_q + IDX_ONE;
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end else begin
                        op_a_d     = Data1_O;
                        op_b_d     = Data2_O;
                        op_valid_d = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end else begin
                    wait_d = wait_q + WAIT_ONE;
                end
            end
            S_ISSUE: begin
                if (op_valid_q && Op_Ready) begin
                    op_valid_d = 1'b0;
                    if (last_pair) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_ONE;
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            m_sel_q    <= 1'b0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
            cnt_q      <= '0;
            wait_q     <= '0;
`ifdef ZERO_SKIP_EN
            skip_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            m_sel_q    <= m_sel_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            wait_q     <= wait_d;
`ifdef ZERO_SKIP_EN
            skip_cnt_q <= skip_cnt_d;
`endif
        end
    end

    assign Addr     = addr_q;
    assign W_En     = 1'b0;
    assign M_Sel    = m_sel_q;
    assign Op_A     = op_a_q;
    assign Op_B     = op_b_q;
    assign Op_Valid = op_valid_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

endmodule
